// File: rtl/sfifo_wr_if.sv
// sfifo_wr_if: WISHBONE slave that pushes CPU command words into the SYNC_FIFO.
// Offers blocking one-word (DO16) and two-word (DO32) pushes, a non-blocking
// push (DONB) that drops the word and sets a sticky overflow flag when the FIFO
// is full, a push counter and a full/overflow status register.
//
// Handshake: a request is cyc & stb & ~wb_ack_o. The slave answers each request
// with exactly one single-cycle wb_ack_o, decoded from the registered ACK state.
// On the FIFO side a word is transferred in every cycle where sfifo_wr_o is high.
// sfifo_wr_o is never raised while sfifo_full_i is high; the blocking pushes
// wait in PUSH_HI/PUSH_LO for as long as the FIFO stays full.
module sfifo_wr_if #(
    parameter int WB_AW    = 5,
    parameter int WB_DW    = 32,
    parameter int SFIFO_DW = 16,
    parameter int CNT_W    = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [WB_AW-1:2]    wb_adr_i,
    input  logic [WB_DW-1:0]    wb_dat_i,
    output logic [WB_DW-1:0]    wb_dat_o,
    output logic                wb_ack_o,
    output logic                sfifo_wr_o,
    output logic [SFIFO_DW-1:0] sfifo_do,
    input  logic                sfifo_full_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_HI = 2'd1,
        PUSH_LO = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [WB_AW-1:2] ADR_CTRL = 'd0;
    localparam logic [WB_AW-1:2] ADR_CNT  = 'd1;
    localparam logic [WB_AW-1:2] ADR_DO16 = 'd2;
    localparam logic [WB_AW-1:2] ADR_DO32 = 'd3;
    localparam logic [WB_AW-1:2] ADR_DONB = 'd4;

    state_t              state_q, state_d;
    logic [SFIFO_DW-1:0] hi_q, lo_q;
    logic                is32_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;

    logic                req, push_req, donb_req, ctrl_wr;
    logic [WB_DW-1:0]    rd_data;
    logic                unused_sel;

    // Byte selects carry no meaning here: every access is a full word.
    assign unused_sel = ^wb_sel_i;

    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign push_req = req & wb_we_i & ((wb_adr_i == ADR_DO16) | (wb_adr_i == ADR_DO32));
    assign donb_req = req & wb_we_i & (wb_adr_i == ADR_DONB);
    assign ctrl_wr  = req & wb_we_i & (wb_adr_i == ADR_CTRL);

    // Ack comes straight from the registered state so it is one clean cycle.
    assign wb_ack_o = (state_q == ACK);

    // Read mux: only CTRL and CNT return data, every other read returns zero.
    always_comb begin
        rd_data = '0;
        if (!wb_we_i) begin
            if (wb_adr_i == ADR_CTRL) rd_data = WB_DW'({ovf_q, sfifo_full_i});
            else if (wb_adr_i == ADR_CNT) rd_data = WB_DW'(cnt_q);
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic and FIFO push strobe/data mux.
    always_comb begin
        state_d    = state_q;
        sfifo_wr_o = 1'b0;
        sfifo_do   = '0;
        case (state_q)
            IDLE: begin
                if (push_req)  state_d = PUSH_HI;
                else if (req)  state_d = ACK;
                if (donb_req && !sfifo_full_i) begin
                    sfifo_wr_o = 1'b1;
                    sfifo_do   = wb_dat_i[WB_DW-1 -: SFIFO_DW];
                end
            end
            PUSH_HI: begin
                if (!sfifo_full_i) begin
                    sfifo_wr_o = 1'b1;
                    sfifo_do   = hi_q;
                    state_d    = is32_q ? PUSH_LO : ACK;
                end
            end
            PUSH_LO: begin
                if (!sfifo_full_i) begin
                    sfifo_wr_o = 1'b1;
                    sfifo_do   = lo_q;
                    state_d    = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A reset cycle must never push: this is what drops a pending LO word.
        if (!wb_rst_ni) begin
            sfifo_wr_o = 1'b0;
            sfifo_do   = '0;
        end
    end

    // Datapath: latched push data, read data, counter and sticky overflow.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wb_dat_o <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is32_q   <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (sfifo_wr_o) cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == IDLE && req) begin
                wb_dat_o <= rd_data;
                if (push_req) begin
                    hi_q   <= wb_dat_i[WB_DW-1 -: SFIFO_DW];
                    lo_q   <= wb_dat_i[SFIFO_DW-1:0];
                    is32_q <= (wb_adr_i == ADR_DO32);
                end
                if (ctrl_wr) begin
                    if (wb_dat_i[0]) ovf_q <= 1'b0;
                    if (wb_dat_i[1]) cnt_q <= '0;
                end
                if (donb_req && sfifo_full_i) ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sfifo_wr_if.sv
// tb_sfifo_wr_if: directed bench for sfifo_wr_if. Bus transactions push their
// expected read data and FIFO words into queues; a monitor on the falling edge
// pops and compares whenever the DUT acks or pushes.
module tb_sfifo_wr_if;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [4:2]  wb_adr_i = 3'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        sfifo_wr_o;
  logic [15:0] sfifo_do;
  logic        sfifo_full_i = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic mon_en = 1'b0;

  logic [15:0] exp_push_q[$];
  logic [31:0] exp_ack_q[$];

  sfifo_wr_if dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_sel_i    (wb_sel_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .sfifo_wr_o  (sfifo_wr_o),
    .sfifo_do    (sfifo_do),
    .sfifo_full_i(sfifo_full_i)
  );

  // clock
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge wb_clk_i) begin
    if (mon_en) begin
      if (sfifo_wr_o) begin
        check("push_while_full", {31'd0, sfifo_full_i}, 32'd0);
        if (exp_push_q.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL unexpected_push: got 0x%0h, expected no push", sfifo_do);
        end else begin
          check("push_data", {16'd0, sfifo_do}, {16'd0, exp_push_q.pop_front()});
        end
      end
      if (wb_ack_o) begin
        if (exp_ack_q.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL unexpected_ack: got ack with 0x%0h, expected no ack", wb_dat_o);
        end else begin
          check("ack_rdata", wb_dat_o, exp_ack_q.pop_front());
        end
      end
    end
  end

  // driver: one WISHBONE transaction, called #1 after a rising edge
  task automatic wb_xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                         input logic [31:0] exp_rd, input int exp_lat, input string name);
    int lat = 0;
    exp_ack_q.push_back(exp_rd);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = 4'hf;
    do begin
      @(posedge wb_clk_i); #1;
      lat++;
    end while (!wb_ack_o && lat < 64);
    check({name, "_latency"}, lat, exp_lat);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 32'd0;
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    // 1: reset and idle
    wb_rst_ni = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_wr", {31'd0, sfifo_wr_o}, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    check("rst_do", {16'd0, sfifo_do}, 32'd0);
    mon_en = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_xfer(3'd1, 1'b0, 32'd0, 32'd0, 1, "rd_cnt_rst");
    wb_xfer(3'd0, 1'b0, 32'd0, 32'd0, 1, "rd_ctrl_rst");

    // 2: DO32, FIFO never full
    exp_push_q.push_back(16'hABCD);
    exp_push_q.push_back(16'h1234);
    wb_xfer(3'd3, 1'b1, 32'hABCD_1234, 32'd0, 3, "do32");
    wb_xfer(3'd1, 1'b0, 32'd0, 32'd2, 1, "rd_cnt_2");

    // 3: DO16 with the FIFO full for the first five cycles
    exp_push_q.push_back(16'h55AA);
    fork
      begin
        sfifo_full_i = 1'b1;
        repeat (5) @(posedge wb_clk_i);
        #1 sfifo_full_i = 1'b0;
      end
      wb_xfer(3'd2, 1'b1, 32'h55AA_0000, 32'd0, 6, "do16_full");
    join

    // 4: DO32 with the FIFO going full for 4 cycles between HI and LO
    exp_push_q.push_back(16'h1111);
    exp_push_q.push_back(16'h2222);
    fork
      begin
        repeat (2) @(posedge wb_clk_i);
        #1 sfifo_full_i = 1'b1;
        repeat (4) @(posedge wb_clk_i);
        #1 sfifo_full_i = 1'b0;
      end
      wb_xfer(3'd3, 1'b1, 32'h1111_2222, 32'd0, 7, "do32_lo_stall");
    join
    wb_xfer(3'd1, 1'b0, 32'd0, 32'd5, 1, "rd_cnt_5");

    // 5: DONB while full drops the word and sets ovf
    sfifo_full_i = 1'b1;
    wb_xfer(3'd4, 1'b1, 32'h7777_0000, 32'd0, 1, "donb_full");
    wb_xfer(3'd0, 1'b0, 32'd0, 32'd3, 1, "rd_ctrl_ovf");
    wb_xfer(3'd0, 1'b1, 32'd1, 32'd0, 1, "wr_ctrl_clr_ovf");
    wb_xfer(3'd0, 1'b0, 32'd0, 32'd1, 1, "rd_ctrl_full");
    sfifo_full_i = 1'b0;
    wb_xfer(3'd0, 1'b0, 32'd0, 32'd0, 1, "rd_ctrl_clear");
    wb_xfer(3'd1, 1'b0, 32'd0, 32'd5, 1, "rd_cnt_after_drop");

    // unmapped and write-only offsets
    wb_xfer(3'd2, 1'b0, 32'd0, 32'd0, 1, "rd_do16");
    wb_xfer(3'd5, 1'b1, 32'hFFFF_FFFF, 32'd0, 1, "wr_unmapped");
    wb_xfer(3'd1, 1'b0, 32'd0, 32'd5, 1, "rd_cnt_unmapped");

    // 6: counter wrap
    wb_xfer(3'd0, 1'b1, 32'd2, 32'd0, 1, "wr_ctrl_clr_cnt");
    wb_xfer(3'd1, 1'b0, 32'd0, 32'd0, 1, "rd_cnt_cleared");
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(negedge wb_clk_i);
    release dut.cnt_q;
    @(posedge wb_clk_i); #1;
    wb_xfer(3'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, 1, "rd_cnt_max");
    exp_push_q.push_back(16'hBEEF);
    wb_xfer(3'd4, 1'b1, 32'hBEEF_0000, 32'd0, 1, "donb_push");
    wb_xfer(3'd1, 1'b0, 32'd0, 32'd0, 1, "rd_cnt_wrap");

    // 6: reset between the HI and LO pushes of a DO32
    exp_push_q.push_back(16'hCAFE);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 3'd3; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hf;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 32'd0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    repeat (4) begin
      @(negedge wb_clk_i);
      check("abort_no_ack", {31'd0, wb_ack_o}, 32'd0);
      check("abort_no_wr", {31'd0, sfifo_wr_o}, 32'd0);
    end
    @(posedge wb_clk_i); #1;
    wb_xfer(3'd1, 1'b0, 32'd0, 32'd0, 1, "rd_cnt_after_rst");
    wb_xfer(3'd0, 1'b0, 32'd0, 32'd0, 1, "rd_ctrl_after_rst");

    // drain check
    repeat (3) @(posedge wb_clk_i);
    check("push_q_left", exp_push_q.size(), 32'd0);
    check("ack_q_left", exp_ack_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
